// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: gates commands onto the
// unit, shadows its latency, raises md-class stalls and returns HI/LO for mfhi/mflo.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic        e_hold,
    input  logic [3:0]  e_md_op,
    input  logic [1:0]  e_mf_sel,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        cancel,
    output logic [3:0]  md_op,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        stall,
    output logic [31:0] mf_data,
    output logic        protocol_err,
    output logic [31:0] stall_cnt
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_protocol_err;
    logic [31:0]     r_stall_cnt;

    logic            w_op_valid;
    logic            w_mf_valid;
    logic            w_mdi;
    logic            w_busy_m;
    logic            w_issue_ok;
    logic            w_issue;
    logic            w_issue_mul;
    logic            w_issue_div;

    assign w_op_valid  = (e_md_op >= 4'd1) && (e_md_op <= 4'd6);
    assign w_mf_valid  = (e_mf_sel == 2'd1) || (e_mf_sel == 2'd2);
    assign w_mdi       = e_valid && (w_op_valid || w_mf_valid);
    assign w_busy_m    = (r_cnt != '0);
    assign w_issue_ok  = e_valid && !e_hold && !cancel && !w_busy_m;
    assign w_issue     = w_issue_ok && w_op_valid;
    assign w_issue_mul = w_issue && ((e_md_op == 4'd1) || (e_md_op == 4'd2));
    assign w_issue_div = w_issue && ((e_md_op == 4'd5) || (e_md_op == 4'd6));

    // The issuing instruction leaves E, so stall only covers later md-class work.
    assign stall        = w_mdi && w_busy_m;
    assign md_op        = w_issue ? e_md_op : '0;
    assign md_rs        = e_rs;
    assign md_rt        = e_rt;
    assign protocol_err = r_protocol_err;
    assign stall_cnt    = r_stall_cnt;

    // HI/LO are written by the unit on the edge its count reaches zero.
    always_comb begin
        mf_data = '0;
        if (!w_busy_m) begin
            if (e_mf_sel == 2'd1) begin
                mf_data = md_hi;
            end else if (e_mf_sel == 2'd2) begin
                mf_data = md_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_protocol_err <= 1'b0;
            r_stall_cnt    <= '0;
        end else begin
            if (md_busy != w_busy_m) begin
                r_protocol_err <= 1'b1;
            end
            if (stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_issue_mul) begin
                        r_cnt   <= CW'(MUL_LAT);
                        r_state <= RUN;
                    end else if (w_issue_div) begin
                        r_cnt   <= CW'(DIV_LAT);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
